// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time with WAIT_CYCLES wait states.
// Optional BYTE_STROBE_EN: when defined, req_wstrb selects the written byte lanes.
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int AW          = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_rdy, r_vld, r_err;
   logic [31:0] r_rdata;
   logic        w_rdy_nxt, w_vld_nxt, w_err_nxt;
   logic [31:0] w_rdata_nxt;

   logic        r_we;
   logic [31:0] r_addr, r_wdata;
   logic [31:0] r_mem [DEPTH];

   logic          w_accept, w_access, w_use_in, w_we, w_err, w_wr;
   logic [31:0]   w_addr, w_wdata;
   logic [AW-1:0] w_idx;
   logic [3:0]    w_be;

   assign w_accept = req_valid && r_rdy;
   assign w_access = (r_state == S_IDLE && w_accept && WAIT_CYCLES == 0) ||
                     (r_state == S_WAIT && r_cnt == 4'd0);

   // With no wait states the access happens on the accept edge, straight from the inputs.
   assign w_use_in = (r_state == S_IDLE);
   assign w_we     = w_use_in ? req_we    : r_we;
   assign w_addr   = w_use_in ? req_addr  : r_addr;
   assign w_wdata  = w_use_in ? req_wdata : r_wdata;
   assign w_idx    = w_addr[AW+1:2];
   // Range check uses the whole word address so aliases above the RAM are rejected.
   assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= DEPTH_W);
   assign w_wr     = reset && w_access && w_we && !w_err;

`ifdef BYTE_STROBE_EN
   logic [3:0] r_wstrb;
   assign w_be = w_use_in ? req_wstrb : r_wstrb;
`else
   logic w_unused_wstrb;
   assign w_unused_wstrb = ^req_wstrb;
   assign w_be = 4'hF;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdy   <= 1'b0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
`ifdef BYTE_STROBE_EN
         r_wstrb <= 4'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rdy   <= w_rdy_nxt;
         r_vld   <= w_vld_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
`ifdef BYTE_STROBE_EN
            r_wstrb <= req_wstrb;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (WAIT_CYCLES == 0) w_state_nxt = S_RESP;
            else begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_RESP: if (r_vld && rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rdy_nxt   = r_rdy;
      w_vld_nxt   = r_vld;
      w_err_nxt   = r_err;
      w_rdata_nxt = r_rdata;
      case (r_state)
         S_IDLE: w_rdy_nxt = !w_accept;
         S_RESP: if (r_vld && rsp_ready) begin
            w_vld_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
            w_rdata_nxt = 32'd0;
            w_rdy_nxt   = 1'b1;
         end
         default: ;
      endcase
      if (w_access) begin
         w_vld_nxt   = 1'b1;
         w_err_nxt   = w_err;
         w_rdata_nxt = (!w_err && !w_we) ? r_mem[w_idx] : 32'd0;
      end
   end

   assign req_ready = r_rdy;
   assign rsp_valid = r_vld;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses 0.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Present one request and hold it for the accept edge; inputs are scrambled afterwards.
   task automatic send(input int s, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st);
      int t = 0;
      while (req_ready[s] !== 1'b1 && t < 20) begin step(); t++; end
      req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a;
      req_wdata[s] = d; req_wstrb[s] = st;
      step();
      req_valid[s] = 1'b0; req_we[s] = ~we; req_addr[s] = 32'hFFFF_FFFC;
      req_wdata[s] = ~d; req_wstrb[s] = ~st;
   endtask

   // Count edges until rsp_valid (cyc=-1 on timeout), sample, optionally handshake.
   task automatic wait_rsp(input int s, input bit hs, output int cyc,
                           output logic [31:0] d, output logic e);
      cyc = 0;
      while (rsp_valid[s] !== 1'b1 && cyc < 40) begin step(); cyc++; end
      if (rsp_valid[s] !== 1'b1) cyc = -1;
      d = rsp_rdata[s]; e = rsp_err[s];
      if (hs) begin rsp_ready[s] = 1'b1; step(); rsp_ready[s] = 1'b0; end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 0; req_we[s] = 0; req_addr[s] = 0; req_wdata[s] = 0;
         req_wstrb[s] = 0; rsp_ready[s] = 0;
      end
      step(); step();
      n_chk++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready[0]); end
      n_chk++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[0]); end
      n_chk++; if (rsp_rdata[0] !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata[0]); end
      n_chk++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err[0]); end
      reset = 1'b1;
      #1;
      n_chk++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL release_req_ready got %b want 0", req_ready[0]); end
      step();
      n_chk++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL first_edge_req_ready got %b want 1", req_ready[0]); end
      n_chk++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL first_edge_req_ready0 got %b want 1", req_ready[1]); end
   endtask

   task automatic test_store_load();
      int c; logic [31:0] d; logic e;
      send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      n_chk++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL wait_req_ready got %b want 0", req_ready[0]); end
      wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (c !== 2) begin n_fail++; $display("FAIL store_latency got %0d want 2", c); end
      n_chk++; if (d !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL store_rsp got %h/%b want 0/0", d, e); end
      send(0, 1'b0, 32'h10, 32'h0, 4'h0);
      wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (c !== 2) begin n_fail++; $display("FAIL load_latency got %0d want 2", c); end
      n_chk++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL load_rdata got %h/%b want deadbeef/0", d, e); end
   endtask

   task automatic test_strobe();
      int c; logic [31:0] d; logic e;
      logic [31:0] exp1, exp2;
`ifdef BYTE_STROBE_EN
      exp1 = 32'h11BB33DD; exp2 = 32'h11BB33DD;
`else
      exp1 = 32'hAABBCCDD; exp2 = 32'h99999999;
`endif
      send(0, 1'b1, 32'h20, 32'h11223344, 4'hF); wait_rsp(0, 1'b1, c, d, e);
      send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101); wait_rsp(0, 1'b1, c, d, e);
      send(0, 1'b0, 32'h20, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (d !== exp1) begin n_fail++; $display("FAIL strobe_merge got %h want %h", d, exp1); end
      send(0, 1'b1, 32'h20, 32'h99999999, 4'b0000); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (c !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL strobe_zero_rsp got lat %0d err %b want 2/0", c, e); end
      send(0, 1'b0, 32'h20, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (d !== exp2) begin n_fail++; $display("FAIL strobe_zero_data got %h want %h", d, exp2); end
   endtask

   task automatic test_errors();
      int c; logic [31:0] d; logic e;
      send(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF); wait_rsp(0, 1'b1, c, d, e);
      send(0, 1'b0, 32'h12, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (e !== 1'b1 || d !== 32'd0) begin n_fail++; $display("FAIL misaligned got err %b data %h want 1/0", e, d); end
      send(0, 1'b1, 32'h1000, 32'h55555555, 4'hF); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (e !== 1'b1 || d !== 32'd0 || c !== 2) begin n_fail++; $display("FAIL out_of_range got err %b data %h lat %0d want 1/0/2", e, d, c); end
      send(0, 1'b0, 32'h0, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin n_fail++; $display("FAIL word0_intact got %h/%b want cafef00d/0", d, e); end
   endtask

   task automatic test_backpressure();
      int c; logic [31:0] d; logic e;
      send(0, 1'b0, 32'h10, 32'h0, 4'h0);
      wait_rsp(0, 1'b0, c, d, e);
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
      req_wdata[0] = 32'h0BADBAD0; req_wstrb[0] = 4'hF;
      for (int k = 0; k < 5; k++) begin
         step();
         n_chk++;
         if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d got v%b d%h e%b rdy%b want v1 ddeadbeef e0 rdy0",
                     k, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
         end
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1; step(); rsp_ready[0] = 1'b0;
      n_chk++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL after_handshake got v%b rdy%b want v0 rdy1", rsp_valid[0], req_ready[0]); end
      send(0, 1'b0, 32'h10, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ignored_req got %h want deadbeef", d); end
   endtask

   task automatic test_reset_mid();
      int c; logic [31:0] d; logic e;
      send(0, 1'b1, 32'h40, 32'h0, 4'hF); wait_rsp(0, 1'b1, c, d, e);
      send(0, 1'b1, 32'h40, 32'h12345678, 4'hF);
      reset = 1'b0;
      #1;
      n_chk++;
      if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got rdy%b v%b d%h e%b want all 0", req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
      end
      step(); step();
      reset = 1'b1;
      step();
      n_chk++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset got v%b rdy%b want v0 rdy1", rsp_valid[0], req_ready[0]); end
      send(0, 1'b0, 32'h40, 32'h0, 4'h0); wait_rsp(0, 1'b1, c, d, e);
      n_chk++; if (d !== 32'd0 || c !== 2) begin n_fail++; $display("FAIL discarded_store got %h lat %0d want 0/2", d, c); end
   endtask

   task automatic test_back_to_back();
      int c; logic [31:0] d; logic e;
      logic exp_v; logic [31:0] exp_d;
      send(1, 1'b1, 32'h10, 32'h01010101, 4'hF); wait_rsp(1, 1'b1, c, d, e);
      n_chk++; if (c !== 0 || e !== 1'b0) begin n_fail++; $display("FAIL zero_wait_latency got %0d/%b want 0/0", c, e); end
      send(1, 1'b1, 32'h14, 32'h02020202, 4'hF); wait_rsp(1, 1'b1, c, d, e);
      n_chk++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got rdy%b want 1", req_ready[1]); end
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; rsp_ready[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         exp_v = (k % 2 == 0);
         exp_d = !exp_v ? 32'd0 : (((k / 2) % 2 == 0) ? 32'h01010101 : 32'h02020202);
         n_chk++;
         if (rsp_valid[1] !== exp_v || rsp_rdata[1] !== exp_d || req_ready[1] !== !exp_v) begin
            n_fail++;
            $display("FAIL b2b_edge%0d got v%b d%h rdy%b want v%b d%h rdy%b",
                     k, rsp_valid[1], rsp_rdata[1], req_ready[1], exp_v, exp_d, !exp_v);
         end
         if (exp_v) req_addr[1] = ((k / 2) % 2 == 0) ? 32'h14 : 32'h10;
      end
      req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_strobe();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port. Serves one load/store at a time over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states so the core's memory-stall path can be exercised.
- Sits between the core's load/store unit and the data RAM and replaces the zero-latency combinational memory.

Parameters:
- DEPTH, 1024, number of 32-bit words stored.
- AW, 10, word-index width; must satisfy 2**AW >= DEPTH.
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; range 0..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte lanes for a store; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset values (reset low): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- req_ready rises on the first clk edge after reset is released.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting wait states.
  - RESP: rsp_valid=1.
- IDLE transitions:
  - On an edge with req_valid&&req_ready, capture req_we/addr/wdata/wstrb and drop req_ready.
  - If WAIT_CYCLES=0, go straight to the access step below.
  - Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: decrement each edge. The edge on which the counter equals 0 performs the access and moves to RESP.
- Access step:
  - word index = addr[AW+1:2].
  - err = (addr[1:0]!=0) || (index >= DEPTH).
  - Load without err: rsp_rdata = mem[index].
  - Store without err: write the enabled lanes, rsp_rdata=0.
  - err: no RAM change, rsp_rdata=0, rsp_err=1.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+WAIT_CYCLES. With WAIT_CYCLES=0 that is after edge N itself.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, state=IDLE.
- No overlap: req_ready=0 in WAIT and RESP, and a request presented there is ignored until IDLE.
- Peak throughput is one transaction per WAIT_CYCLES+2 cycles when rsp_ready is held high.
- Request inputs are sampled only on the accept edge; later changes have no effect.
- Reset mid-operation (in WAIT or RESP): return immediately to reset values.
  - A pending store not yet performed is discarded.
  - A store already performed stays in RAM.
- A load issued after a store to the same word returns the updated data (sequential transactions).

Optional Feature:
- Macro BYTE_STROBE_EN.
- Defined: req_wstrb selects the written lanes. wstrb=4'b0000 is a legal no-op store that still returns a response with rsp_err=0.
- Undefined: req_wstrb is ignored and every non-error store writes all 32 bits.

Test Plan:
- Reset, then release with WAIT_CYCLES=2: req_ready=0 during reset, 1 after the first edge post-release. Store 0xDEADBEEF to 0x0000_0010, accepted at edge N → rsp_valid=1 after edge N+2, rsp_rdata=0, rsp_err=0. Load 0x10 → rsp_rdata=0xDEADBEEF.
- With BYTE_STROBE_EN defined: word 0x20 holds 0x11223344; store 0xAABBCCDD with wstrb=4'b0101; load 0x20 → 0x11BB33DD. With BYTE_STROBE_EN undefined the same load returns 0xAABBCCDD.
- Load from 0x0000_0012 → rsp_err=1, rsp_rdata=0. Store to 0x0000_1000 (index 1024 = DEPTH) → rsp_err=1, and RAM word 0 is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP: rsp_valid, rsp_rdata and rsp_err stay stable, req_ready stays 0, and a second req_valid is not accepted. Raise rsp_ready → one handshake, then req_ready=1 on the next cycle.
- Accept a store to 0x40 of 0x12345678 (word held 0), then pull reset low in WAIT before the access edge: all outputs at reset values, and a load of 0x40 after release returns 0.
- WAIT_CYCLES=0 with rsp_ready held high and back-to-back loads: one response every 2 cycles, each arriving on the cycle after its accept edge.
